req_encoder_32x5_seq: RTL
=========================

// Module: req_encoder_32x5_seq
// PURPOSE
//   Registered 32-to-5 request encoder; the inverse direction of the 5x32 decoder.
//   Captures one-hot or multi-hot request pulses on 32 lines into a pending set.
//   Offers the pending requests one at a time as a 5-bit index over a valid/ready handshake.
//   Used to turn the decoder's line space back into binary addresses, e.g. for an interrupt/event funnel.
// PARAMETERS
//   N_REQ        32  number of request lines (fixed 32 in this revision)
//   IDX_W        5   index width, log2(N_REQ)
//   LOWEST_FIRST 1   1: lowest set bit has priority; 0: highest set bit has priority
// PORTS
//   clk       in   1      rising-edge clock, single domain
//   rst_n     in   1      synchronous reset, active-low
//   enable    in   1      1: requests are captured; 0: req ignored (drain continues)
//   req       in   32     request pulses; bit i sets pending[i] on the clock edge
//   idx       out  5      encoded index of the offered request
//   valid     out  1      idx is valid
//   ready     in   1      consumer accepts idx when valid&&ready at an edge
//   pend_cnt  out  6      number of pending bits (0..32), registered
//   dup       out  1      sticky: request seen on an already-pending line
//   clr_dup   in   1      clears dup (its set has priority on the same edge)
// BEHAVIOUR
//   Reset (rst_n=0 at edge): pending=0, state=IDLE, idx=0, valid=0, pend_cnt=0, dup=0.
//   Reset mid-offer drops all pending and the offered index; no handshake completes that edge.
//   Pending update per edge:
//     pending' = (pending & ~clr_mask) | (enable ? req : 0)
//     clr_mask = onehot(idx) when valid&&ready, else 0. Set wins over clear on the same bit.
//   dup' = 1 if enable && (req & pending & ~clr_mask) != 0; else 0 if clr_dup; else dup.
//   pend_cnt' = popcount(pending'). Saturation is impossible because pending is 32 bits.
//   Priority encode: pri(x) = index of the lowest (LOWEST_FIRST=1) or highest set bit of x.
//   FSM:
//     IDLE (valid=0):
//       pending != 0 -> load idx = pri(pending); go to OFFER.
//       Otherwise stay in IDLE.
//     OFFER (valid=1):
//       idx is held stable while ready=0.
//       On valid&&ready, let rem = pending & ~onehot(idx).
//         rem != 0 -> idx = pri(rem); stay in OFFER. Back-to-back, one index per cycle.
//         rem == 0 -> valid = 0; go to IDLE.
//       Requests captured on the handshake edge are not in rem. They are offered from
//       IDLE one cycle later.
//   Latency: req high at edge t -> pending at t -> valid/idx at edge t+1 (2-cycle req-to-valid).
//   An offered idx is never pre-empted by a higher-priority arrival. Priority is re-evaluated
//   only at load.
//   A line re-requested while it is offered (no handshake) -> dup=1 and the line stays pending.
//   A line re-requested on its own handshake edge -> re-pending, no dup. It is offered again later.
//   enable=0 does not stop draining. Only the capture of new requests stops.
//   ready while valid=0 has no effect.
// TESTING
//   Reset, then req=32'h0000_0001 for 1 cycle, ready=1 -> valid at 2nd edge, idx=0,
//     then valid=0 and pend_cnt=0.
//   req=32'h8000_0011 in 1 cycle, ready=1, LOWEST_FIRST=1 -> idx 0,4,31 on consecutive
//     cycles; pend_cnt 3,2,1,0.
//   Same stimulus with ready=0 for 5 cycles -> idx=0 held, valid=1, pend_cnt=3;
//     then ready=1 -> drains as above.
//   Offered idx=4 with ready=0, req[4] pulsed -> dup=1; clr_dup -> dup=0; req[4] on the
//     handshake edge -> 4 offered again, dup=0.
//   enable=0, req=32'hFFFF_FFFF -> pending stays 0, valid=0; enable=1 for 1 cycle ->
//     pend_cnt=32, 32 indices drained 0..31.
//   rst_n=0 during OFFER with pend_cnt=5 -> next edge valid=0, pend_cnt=0, dup=0;
//     nothing is offered afterwards.

Source files
------------

// File: rtl/req_encoder_32x5_seq.sv
// Registered 32-to-5 request encoder.
// Request pulses are collected into a pending set. The pending lines are then
// offered one at a time as a binary index over a valid/ready handshake.
module req_encoder_32x5_seq #(
    parameter int unsigned N_REQ        = 32,
    parameter int unsigned IDX_W        = 5,
    parameter bit          LOWEST_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [N_REQ-1:0]   req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid,
    input  logic               ready,
    output logic [IDX_W:0]     pend_cnt,
    output logic               dup,
    input  logic               clr_dup
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_pending;
    logic [IDX_W-1:0]   r_idx;
    logic               r_valid;
    logic [IDX_W:0]     r_pend_cnt;
    logic               r_dup;

    logic               w_hs;
    logic [N_REQ-1:0]   w_idx_oh;
    logic [N_REQ-1:0]   w_clr_mask;
    logic [N_REQ-1:0]   w_set_mask;
    logic [N_REQ-1:0]   w_pend_next;
    logic [N_REQ-1:0]   w_rem;
    logic               w_dup_hit;
    logic [IDX_W:0]     w_cnt_next;

    // Index of the lowest (or highest) set bit; later matches overwrite
    // earlier ones, so the scan order decides which end wins.
    function automatic logic [IDX_W-1:0] pri(input logic [N_REQ-1:0] x);
        logic [IDX_W-1:0] p;
        logic [IDX_W-1:0] k;
        p = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (LOWEST_FIRST) begin
                k = IDX_W'(N_REQ - 1 - i);
            end else begin
                k = IDX_W'(i);
            end
            if (x[k]) begin
                p = k;
            end
        end
        return p;
    endfunction

    assign w_hs        = r_valid & ready;
    assign w_idx_oh    = N_REQ'(1) << r_idx;
    assign w_clr_mask  = w_hs ? w_idx_oh : '0;
    assign w_set_mask  = enable ? req : '0;
    // Set wins over clear: a line re-requested on its own handshake stays pending.
    assign w_pend_next = (r_pending & ~w_clr_mask) | w_set_mask;
    // Candidates for the next back-to-back offer exclude this edge's captures.
    assign w_rem       = r_pending & ~w_idx_oh;
    assign w_dup_hit   = |(w_set_mask & r_pending & ~w_clr_mask);

    // Population count of the next pending set, registered as pend_cnt.
    always_comb begin
        w_cnt_next = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_cnt_next = w_cnt_next + (IDX_W+1)'(w_pend_next[i]);
        end
    end

    // Pending set, sticky dup flag and the offer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_pend_cnt <= '0;
            r_dup      <= 1'b0;
        end else begin
            r_pending  <= w_pend_next;
            r_pend_cnt <= w_cnt_next;

            if (w_dup_hit) begin
                r_dup <= 1'b1;
            end else if (clr_dup) begin
                r_dup <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pending != '0) begin
                        r_idx   <= pri(r_pending);
                        r_valid <= 1'b1;
                        r_state <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (ready) begin
                        if (w_rem != '0) begin
                            r_idx <= pri(w_rem);
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign idx      = r_idx;
    assign valid    = r_valid;
    assign pend_cnt = r_pend_cnt;
    assign dup      = r_dup;

endmodule
